// File: rtl/conv2d_kernel_scheduler_if.sv
// ---------------------------------------------------------------------------
// conv2d_kernel_scheduler_if
//
// Purpose: bundles every non-clock signal between the Conv2d kernel
// scheduler and its environment (conv controller, kernel BRAM, MAC array).
//
// Handshake: the scheduler presents a kernel word by raising kernel_valid
// and holds kernel_valid, ch_index and oc_index stable until the MAC engine
// samples kernel_ready=1 on a rising clk edge with kernel_valid=1; that edge
// is the transfer. kernel_valid never depends combinationally on
// kernel_ready, and kernel_ready is ignored while kernel_valid is low.
//
// Signals (direction given for the master = scheduler side):
//   start             in   one-cycle layer request (honoured only in IDLE)
//   CHANNEL_SIZE      in   input channels per kernel set, latched on start
//   OUT_CHANNEL_SIZE  in   output channels, latched on start
//   done_loading_1ker in   kernel BRAM: last word of current set written
//   last_channel      in   kernel BRAM: read address at final channel
//   kernel_ready      in   MAC engine accepts the presented word
//   load_BRAM_dina    out  level, enables kernel BRAM loading
//   update_BRAM_doutb out  one-cycle pulse, advances BRAM read address
//   kernel_valid      out  kernel_BRAM_doutb holds a valid word
//   ch_index          out  input channel of the presented word
//   oc_index          out  current output channel
//   busy              out  high outside IDLE
//   done              out  one-cycle pulse at layer end
//   fsm_state         out  scheduler state encoding, for debug/checkers
//   seq_err           out  sticky sequencing error (only with
//                          KERNEL_SCHED_CHECK_EN defined)
// ---------------------------------------------------------------------------
interface conv2d_kernel_scheduler_if #(
    parameter int CNT_W = 9
);
    logic             start;
    logic [CNT_W-1:0] CHANNEL_SIZE;
    logic [CNT_W-1:0] OUT_CHANNEL_SIZE;
    logic             done_loading_1ker;
    logic             last_channel;
    logic             kernel_ready;
    logic             load_BRAM_dina;
    logic             update_BRAM_doutb;
    logic             kernel_valid;
    logic [CNT_W-1:0] ch_index;
    logic [CNT_W-1:0] oc_index;
    logic             busy;
    logic             done;
    logic [2:0]       fsm_state;
`ifdef KERNEL_SCHED_CHECK_EN
    logic             seq_err;
`endif

    modport master (
        input  start, CHANNEL_SIZE, OUT_CHANNEL_SIZE, done_loading_1ker,
               last_channel, kernel_ready,
        output load_BRAM_dina, update_BRAM_doutb, kernel_valid, ch_index,
               oc_index, busy, done, fsm_state
`ifdef KERNEL_SCHED_CHECK_EN
        , output seq_err
`endif
    );

    modport slave (
        output start, CHANNEL_SIZE, OUT_CHANNEL_SIZE, done_loading_1ker,
               last_channel, kernel_ready,
        input  load_BRAM_dina, update_BRAM_doutb, kernel_valid, ch_index,
               oc_index, busy, done, fsm_state
`ifdef KERNEL_SCHED_CHECK_EN
        , input seq_err
`endif
    );
endinterface

// File: rtl/conv2d_kernel_scheduler.sv
// ---------------------------------------------------------------------------
// conv2d_kernel_scheduler
//
// Purpose: sequencer for the Conv2d kernel BRAM block. For every output
// channel it enables loading of one kernel set, then steps the BRAM read
// port one input channel at a time, presenting each word to the MAC engine
// with a valid/ready handshake. One word is in flight at a time.
//
// Ports:
//   clk      rising-edge system clock
//   Reset_n  asynchronous active-low reset
//   bus      conv2d_kernel_scheduler_if.master (see interface header)
//
// Parameters:
//   RD_LAT   cycles from an update_BRAM_doutb pulse to a valid BRAM word (1..3)
//   CNT_W    width of channel / output-channel counters
//
// Optional build macro: KERNEL_SCHED_CHECK_EN adds the sticky seq_err
// output that flags disagreement between last_channel and the internal
// channel counter, and done_loading_1ker outside LOAD. Sequencing is the
// same with or without it.
// ---------------------------------------------------------------------------
module conv2d_kernel_scheduler #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 9
) (
    input logic                       clk,
    input logic                       Reset_n,
    conv2d_kernel_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_FETCH   = 3'd2,
        S_SERVE   = 3'd3,
        S_NEXT_OC = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // FETCH lasts RD_LAT+1 cycles: the update pulse cycle plus RD_LAT waits.
    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT);

    state_t           state_q;
    logic [CNT_W-1:0] csize_q;
    logic [CNT_W-1:0] osize_q;
    logic [CNT_W-1:0] ch_q;
    logic [CNT_W-1:0] oc_q;
    logic [1:0]       lat_q;
    logic             load_q;
    logic             upd_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic             last_ch;
    logic             last_oc;

    // Sizes are nonzero whenever these are consulted (zero sizes never
    // leave IDLE), so size-1 cannot underflow.
    assign last_ch = (ch_q == csize_q - CNT_ONE);
    assign last_oc = (oc_q == osize_q - CNT_ONE);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            csize_q <= '0;
            osize_q <= '0;
            ch_q    <= '0;
            oc_q    <= '0;
            lat_q   <= '0;
            load_q  <= 1'b0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Pulse outputs default low; states raise them for one cycle.
            upd_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if ((bus.CHANNEL_SIZE != '0) && (bus.OUT_CHANNEL_SIZE != '0)) begin
                            csize_q <= bus.CHANNEL_SIZE;
                            osize_q <= bus.OUT_CHANNEL_SIZE;
                            ch_q    <= '0;
                            oc_q    <= '0;
                            load_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end else begin
                            // Empty layer: report completion without work.
                            done_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.done_loading_1ker) begin
                        load_q  <= 1'b0;
                        upd_q   <= 1'b1;
                        lat_q   <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (lat_q == LAT_LAST) begin
                        valid_q <= 1'b1;
                        state_q <= S_SERVE;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                S_SERVE: begin
                    // kernel_valid is 1 throughout SERVE, so ready alone
                    // marks the transfer edge.
                    if (bus.kernel_ready) begin
                        valid_q <= 1'b0;
                        if (last_ch) begin
                            state_q <= S_NEXT_OC;
                        end else begin
                            ch_q    <= ch_q + CNT_ONE;
                            upd_q   <= 1'b1;
                            lat_q   <= '0;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_NEXT_OC: begin
                    if (last_oc) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        oc_q    <= oc_q + CNT_ONE;
                        ch_q    <= '0;
                        load_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_BRAM_dina    = load_q;
    assign bus.update_BRAM_doutb = upd_q;
    assign bus.kernel_valid      = valid_q;
    assign bus.ch_index          = ch_q;
    assign bus.oc_index          = oc_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.fsm_state         = state_q;

`ifdef KERNEL_SCHED_CHECK_EN
    logic seq_err_q;

    // Sticky until reset: the BRAM's advisory last_channel must agree with
    // the internal counter at every transfer, and load completion may only
    // be signalled while loading.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            seq_err_q <= 1'b0;
        end else if (((state_q == S_SERVE) && bus.kernel_ready &&
                      (bus.last_channel != last_ch)) ||
                     (bus.done_loading_1ker && (state_q != S_LOAD))) begin
            seq_err_q <= 1'b1;
        end
    end

    assign bus.seq_err = seq_err_q;
`else
    // last_channel is advisory; without the checker nothing consumes it.
    logic unused_last_channel;
    assign unused_last_channel = bus.last_channel;
`endif
endmodule

// File: tb/tb_conv2d_kernel_scheduler.sv
module tb_conv2d_kernel_scheduler;
    localparam int RD_LAT = 1;
    localparam int CNT_W  = 9;
    localparam int BUDGET = 4000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    conv2d_kernel_scheduler_if #(.CNT_W(CNT_W)) bus();

    conv2d_kernel_scheduler #(
        .RD_LAT(RD_LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: expected {oc_index, ch_index} of each word, in order.
    logic [2*CNT_W-1:0] exp_q[$];

    // Statistics of the last run_layer call.
    int n_load;
    int n_upd;
    int n_done;
    int n_words;
    int max_load_run;
    bit aborted;

    // Advance to just after the next rising edge (sample and drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.start             = 1'b0;
        bus.CHANNEL_SIZE      = '0;
        bus.OUT_CHANNEL_SIZE  = '0;
        bus.done_loading_1ker = 1'b0;
        bus.last_channel      = 1'b0;
        bus.kernel_ready      = 1'b1;
    endtask

    // ---------------- driver: one full layer ----------------
    // c/o: sizes; load_dly: extra cycles before done_loading_1ker;
    // stall_idx/stall_len: hold kernel_ready low on that word;
    // force_idx: word on which last_channel is forced 1;
    // abort_idx: return (without transferring) when that word is presented.
    task automatic run_layer(input int c, input int o, input int load_dly,
                             input int stall_idx, input int stall_len,
                             input int force_idx, input int abort_idx);
        int load_cnt  = 0;
        int stall_cnt = 0;
        int t_upd     = -100;
        bit dl_prev   = 1'b0;
        bit upd_prev  = 1'b0;
        bit val_prev  = 1'b0;
        bit hs_prev   = 1'b0;
        bit done_prev = 1'b0;
        bit finished  = 1'b0;
        bit hs;
        logic [2*CNT_W-1:0] exp_w;
        n_load = 0; n_upd = 0; n_done = 0; n_words = 0; max_load_run = 0; aborted = 1'b0;
        exp_q.delete();
        for (int oc = 0; oc < o; oc++)
            for (int ch = 0; ch < c; ch++)
                exp_q.push_back({CNT_W'(oc), CNT_W'(ch)});
        bus.CHANNEL_SIZE     = CNT_W'(c);
        bus.OUT_CHANNEL_SIZE = CNT_W'(o);
        bus.start            = 1'b1;
        tick();
        bus.start = 1'b0;
        // Size changes while busy must have no effect.
        bus.CHANNEL_SIZE     = CNT_W'(c + 2);
        bus.OUT_CHANNEL_SIZE = CNT_W'(o + 1);
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (done_prev) begin
                vectors++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fsm_state !== 3'd0) begin
                    miscompares++;
                    $display("FAIL after_done: busy=%b done=%b state=%0d required busy=0 done=0 state=0",
                             bus.busy, bus.done, bus.fsm_state);
                end
                finished = 1'b1;
                break;
            end
            if (hs_prev) begin
                vectors++;
                if (bus.kernel_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bubble: kernel_valid=%b after transfer, required 0", bus.kernel_valid);
                end
            end
            if (dl_prev) begin
                vectors++;
                if (bus.load_BRAM_dina !== 1'b0 || bus.update_BRAM_doutb !== 1'b1) begin
                    miscompares++;
                    $display("FAIL load_exit: load=%b update=%b required load=0 update=1",
                             bus.load_BRAM_dina, bus.update_BRAM_doutb);
                end
            end
            if (bus.load_BRAM_dina === 1'b1) begin
                if (load_cnt == 0) n_load++;
                load_cnt++;
                if (load_cnt > max_load_run) max_load_run = load_cnt;
            end else begin
                load_cnt = 0;
            end
            if (bus.update_BRAM_doutb === 1'b1) begin
                n_upd++;
                t_upd = cyc;
                vectors++;
                if (upd_prev) begin
                    miscompares++;
                    $display("FAIL update_pulse: update high 2 cycles in a row, required 1");
                end
            end
            if (bus.kernel_valid === 1'b1 && !val_prev) begin
                vectors++;
                if (cyc - t_upd != RD_LAT + 1) begin
                    miscompares++;
                    $display("FAIL fetch_latency: %0d cycles update->valid, required %0d",
                             cyc - t_upd, RD_LAT + 1);
                end
            end
            if (bus.done === 1'b1) n_done++;

            // Environment responses for the coming edge.
            bus.done_loading_1ker = (bus.load_BRAM_dina === 1'b1) && (load_cnt == load_dly + 1);
            bus.kernel_ready      = 1'b1;
            bus.last_channel      = 1'b0;
            bus.start             = bus.update_BRAM_doutb; // start while busy must be ignored
            hs = 1'b0;
            if (bus.kernel_valid === 1'b1) begin
                exp_w = (exp_q.size() > 0) ? exp_q[0] : '1;
                vectors++;
                if ({bus.oc_index, bus.ch_index} !== exp_w || bus.update_BRAM_doutb !== 1'b0) begin
                    miscompares++;
                    $display("FAIL word%0d: oc=%0d ch=%0d upd=%b required oc=%0d ch=%0d upd=0",
                             n_words, bus.oc_index, bus.ch_index, bus.update_BRAM_doutb,
                             exp_w[2*CNT_W-1:CNT_W], exp_w[CNT_W-1:0]);
                end
                if (n_words == abort_idx) begin
                    aborted  = 1'b1;
                    finished = 1'b1;
                    break;
                end
                bus.last_channel = (n_words == force_idx) ? 1'b1
                                 : (exp_w[CNT_W-1:0] == CNT_W'(c - 1));
                if (n_words == stall_idx && stall_cnt < stall_len) begin
                    bus.kernel_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    hs = 1'b1;
                    n_words++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
            dl_prev   = bus.done_loading_1ker;
            upd_prev  = bus.update_BRAM_doutb;
            val_prev  = bus.kernel_valid;
            hs_prev   = hs;
            done_prev = bus.done;
            tick();
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: layer c=%0d o=%0d not finished in %0d cycles", c, o, BUDGET);
        end
        bus.start             = 1'b0;
        bus.done_loading_1ker = 1'b0;
        bus.last_channel      = 1'b0;
        bus.kernel_ready      = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.load_BRAM_dina, bus.update_BRAM_doutb, bus.kernel_valid, bus.busy, bus.done} !== 5'b0 ||
            bus.ch_index !== '0 || bus.oc_index !== '0 || bus.fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: ld/up/val/busy/done=%b ch=%0d oc=%0d state=%0d required all 0",
                     {bus.load_BRAM_dina, bus.update_BRAM_doutb, bus.kernel_valid, bus.busy, bus.done},
                     bus.ch_index, bus.oc_index, bus.fsm_state);
        end
`ifdef KERNEL_SCHED_CHECK_EN
        vectors++;
        if (bus.seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_seq_err: got %b required 0", bus.seq_err);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_layer(3, 2, 0, -1, 0, -1, -1);
        vectors++;
        if (n_load != 2) begin miscompares++; $display("FAIL basic_loads: got %0d required 2", n_load); end
        vectors++;
        if (n_upd != 6) begin miscompares++; $display("FAIL basic_updates: got %0d required 6", n_upd); end
        vectors++;
        if (n_words != 6 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_words: got %0d left %0d required 6 left 0", n_words, exp_q.size());
        end
        vectors++;
        if (n_done != 1) begin miscompares++; $display("FAIL basic_done: got %0d required 1", n_done); end
`ifdef KERNEL_SCHED_CHECK_EN
        vectors++;
        if (bus.seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_seq_err: got %b required 0", bus.seq_err);
        end
`endif
    endtask

    task automatic test_stall();
        run_layer(3, 2, 0, 1, 5, -1, -1);
        vectors++;
        if (n_upd != 6) begin miscompares++; $display("FAIL stall_updates: got %0d required 6", n_upd); end
        vectors++;
        if (n_words != 6 || n_done != 1) begin
            miscompares++;
            $display("FAIL stall_words: words=%0d done=%0d required 6 and 1", n_words, n_done);
        end
    endtask

    task automatic test_load_delay();
        run_layer(2, 1, 20, -1, 0, -1, -1);
        vectors++;
        if (max_load_run != 21) begin
            miscompares++;
            $display("FAIL load_length: load high %0d cycles, required 21", max_load_run);
        end
        vectors++;
        if (n_load != 1 || n_upd != 2 || n_done != 1) begin
            miscompares++;
            $display("FAIL load_delay_counts: load=%0d upd=%0d done=%0d required 1 2 1", n_load, n_upd, n_done);
        end
    endtask

    task automatic test_boundary();
        run_layer(1, 1, 0, -1, 0, -1, -1);
        vectors++;
        if (n_load != 1 || n_upd != 1 || n_words != 1 || n_done != 1) begin
            miscompares++;
            $display("FAIL bnd_1x1: load=%0d upd=%0d words=%0d done=%0d required 1 1 1 1",
                     n_load, n_upd, n_words, n_done);
        end
        run_layer(1, 3, 2, -1, 0, -1, -1);
        vectors++;
        if (n_load != 3 || n_upd != 3 || n_words != 3 || n_done != 1) begin
            miscompares++;
            $display("FAIL bnd_1x3: load=%0d upd=%0d words=%0d done=%0d required 3 3 3 1",
                     n_load, n_upd, n_words, n_done);
        end
        run_layer(4, 1, 1, 3, 2, -1, -1);
        vectors++;
        if (n_load != 1 || n_upd != 4 || n_words != 4 || n_done != 1) begin
            miscompares++;
            $display("FAIL bnd_4x1: load=%0d upd=%0d words=%0d done=%0d required 1 4 4 1",
                     n_load, n_upd, n_words, n_done);
        end
    endtask

    task automatic test_zero_size();
        bus.CHANNEL_SIZE     = 9'd0;
        bus.OUT_CHANNEL_SIZE = 9'd3;
        bus.start            = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.load_BRAM_dina !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_ch_done: done=%b busy=%b load=%b required 1 0 0",
                     bus.done, bus.busy, bus.load_BRAM_dina);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_ch_pulse: done=%b second cycle, required 0", bus.done);
        end
        bus.CHANNEL_SIZE     = 9'd5;
        bus.OUT_CHANNEL_SIZE = 9'd0;
        bus.start            = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++;
        if (bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_oc_done: done=%b required 1", bus.done);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.load_BRAM_dina !== 1'b0 || bus.update_BRAM_doutb !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_quiet: load=%b upd=%b busy=%b required 0 0 0",
                         bus.load_BRAM_dina, bus.update_BRAM_doutb, bus.busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_serve();
        run_layer(4, 1, 0, -1, 0, -1, 2);
        vectors++;
        if (!aborted || bus.ch_index !== 9'd2 || bus.kernel_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_serve_reach: aborted=%b ch=%0d valid=%b required 1 2 1",
                     aborted, bus.ch_index, bus.kernel_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.load_BRAM_dina, bus.update_BRAM_doutb, bus.kernel_valid, bus.busy, bus.done} !== 5'b0 ||
            bus.ch_index !== '0 || bus.oc_index !== '0 || bus.fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_reset: ld/up/val/busy/done=%b ch=%0d state=%0d required all 0",
                     {bus.load_BRAM_dina, bus.update_BRAM_doutb, bus.kernel_valid, bus.busy, bus.done},
                     bus.ch_index, bus.fsm_state);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_layer(2, 2, 0, -1, 0, -1, -1);
        vectors++;
        if (n_load != 2 || n_upd != 4 || n_words != 4 || n_done != 1) begin
            miscompares++;
            $display("FAIL after_reset_run: load=%0d upd=%0d words=%0d done=%0d required 2 4 4 1",
                     n_load, n_upd, n_words, n_done);
        end
    endtask

`ifdef KERNEL_SCHED_CHECK_EN
    task automatic test_seq_err();
        run_layer(4, 1, 0, -1, 0, 0, -1);
        vectors++;
        if (bus.seq_err !== 1'b1 || n_done != 1) begin
            miscompares++;
            $display("FAIL seq_err_last: seq_err=%b done=%0d required 1 1", bus.seq_err, n_done);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.done_loading_1ker = 1'b1;
        tick();
        bus.done_loading_1ker = 1'b0;
        tick();
        vectors++;
        if (bus.seq_err !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_err_dl_idle: seq_err=%b busy=%b required 1 0", bus.seq_err, bus.busy);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_load_delay();
        test_boundary();
        test_zero_size();
        test_reset_mid_serve();
`ifdef KERNEL_SCHED_CHECK_EN
        test_seq_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
